// File: rtl/penc_pkg.sv
// penc_pkg: shared width helpers and FSM state type for priority_encoder_q.
package penc_pkg;

    typedef enum logic {PENC_IDLE, PENC_HOLD} penc_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // code_o carries index+1 with 0 reserved for "none", hence N+1 values
    function automatic int code_w(input int n);
        return clog2(n + 1);
    endfunction

endpackage

// File: rtl/penc_pick.sv
// penc_pick: combinational search of cand_i, downward from start_i with wrap; first set bit wins.
module penc_pick import penc_pkg::*; #(
    parameter int N = 9,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  cand_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    int p;
    logic [IW-1:0] pi;
    always_comb begin
        found_o = |cand_i;
        idx_o = '0;
        p = 0;
        pi = '0;
        for (int i = N - 1; i >= 0; i--) begin
            p = (int'(start_i) - i + N) % N;
            pi = IW'(p);
            if (cand_i[pi]) idx_o = pi;
        end
    end
endmodule

// File: rtl/priority_encoder_q.sv
// priority_encoder_q: registered sticky-pending priority encoder with valid/ready output.
// Define PENC_RR_EN for round-robin arbitration instead of fixed priority.
module priority_encoder_q import penc_pkg::*; #(
    parameter int N = 9,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int W = code_w(N),
    localparam int IW = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [W-1:0] code_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] pending_o,
    output logic         any_o
);
    penc_state_t   state_q;
    logic [W-1:0]  code_q, code_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [N-1:0]  req_act, cand;
    logic          load, found;
    logic [IW-1:0] idx, start;

    assign req_act = ACTIVE_LOW ? ~req_i : req_i;
    assign cand    = pending_q | req_act;
    assign load    = (state_q == PENC_IDLE) || ready_i;

    penc_pick #(.N(N)) u_pick (
        .cand_i (cand),
        .start_i(start),
        .found_o(found),
        .idx_o  (idx)
    );

    // granted bit is cleared even if re-requested on the same edge, so a held level re-arms next edge
    always_comb begin
        pending_d = (load && found) ? (cand & ~(N'(1) << idx)) : cand;
        code_d = found ? W'(idx) + W'(1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PENC_IDLE;
            code_q <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (load) begin
                state_q <= found ? PENC_HOLD : PENC_IDLE;
                code_q <= code_d;
            end
        end
    end

`ifdef PENC_RR_EN
    // pointer stores the next search start, i.e. one below the last granted index
    logic [IW-1:0] ptr_q, ptr_d;
    assign start = ptr_q;
    assign ptr_d = (idx == '0) ? IW'(N - 1) : idx - 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= IW'(N - 1);
        else if (load && found) ptr_q <= ptr_d;
    end
`else
    assign start = IW'(N - 1);
`endif

    assign code_o    = code_q;
    assign valid_o   = (state_q == PENC_HOLD);
    assign pending_o = pending_q;
    assign any_o     = (|pending_q) || valid_o;
endmodule

// File: tb/tb_priority_encoder_q.sv
// tb_priority_encoder_q: directed table, async-reset and fairness sequences, then random traffic vs a reference model.
module tb_priority_encoder_q;
    localparam int N = 9;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_i = '1;
    logic         ready_i = 1'b0;
    logic [W-1:0] code_o;
    logic         valid_o;
    logic [N-1:0] pending_o;
    logic         any_o;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] m_pend;
    logic         m_valid;
    int           m_code;
    int           m_last;

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        int           code;
        logic         v;
        logic [N-1:0] pend;
    } vec_t;
    vec_t tbl[17];

    always #5 clk = ~clk;

    priority_encoder_q #(.N(N), .ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .code_o   (code_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .pending_o(pending_o),
        .any_o    (any_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int code, input logic v, input logic [N-1:0] pend);
        chk({tag, ".code"}, 32'(code_o), 32'(code));
        chk({tag, ".valid"}, 32'(valid_o), 32'(v));
        chk({tag, ".pending"}, 32'(pending_o), 32'(pend));
        chk({tag, ".any"}, 32'(any_o), 32'((|pend) || v));
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_valid = 1'b0;
        m_code = 0;
        m_last = 0;
    endtask

    // one clock edge of the reference: pick from pending plus fresh requests when the output slot is free
    task automatic model_edge();
        logic [N-1:0] cand;
        int g;
        cand = m_pend | ~req_i;
        if (!m_valid || ready_i) begin
            g = -1;
`ifdef PENC_RR_EN
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last - k + 2 * N) % N;
                if (g < 0 && cand[i]) g = i;
            end
`else
            for (int i = 0; i < N; i++) if (cand[i]) g = i;
`endif
            if (g >= 0) begin
                cand[g] = 1'b0;
                m_valid = 1'b1;
                m_code = g + 1;
                m_last = g;
            end else begin
                m_valid = 1'b0;
                m_code = 0;
            end
        end
        m_pend = cand;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{9'h1F7, 1'b0, 4, 1'b1, 9'h000};
        tbl[1]  = '{9'h1FF, 1'b0, 4, 1'b1, 9'h000};
        tbl[2]  = '{9'h1FF, 1'b0, 4, 1'b1, 9'h000};
        tbl[3]  = '{9'h1FF, 1'b0, 4, 1'b1, 9'h000};
        tbl[4]  = '{9'h1FF, 1'b1, 0, 1'b0, 9'h000};
        tbl[5]  = '{9'h0FE, 1'b1, 9, 1'b1, 9'h001};
        tbl[6]  = '{9'h1FF, 1'b1, 1, 1'b1, 9'h000};
        tbl[7]  = '{9'h1FF, 1'b1, 0, 1'b0, 9'h000};
        tbl[8]  = '{9'h0FF, 1'b0, 9, 1'b1, 9'h000};
        tbl[9]  = '{9'h1DF, 1'b0, 9, 1'b1, 9'h020};
        tbl[10] = '{9'h1FF, 1'b0, 9, 1'b1, 9'h020};
        tbl[11] = '{9'h1FF, 1'b1, 6, 1'b1, 9'h000};
        tbl[12] = '{9'h1FF, 1'b1, 0, 1'b0, 9'h000};
        tbl[13] = '{9'h0FF, 1'b1, 9, 1'b1, 9'h000};
        tbl[14] = '{9'h0FF, 1'b1, 9, 1'b1, 9'h000};
        tbl[15] = '{9'h0FF, 1'b1, 9, 1'b1, 9'h000};
        tbl[16] = '{9'h1FF, 1'b1, 0, 1'b0, 9'h000};

        req_i = 9'h0FF;
        repeat (5) @(posedge clk);
        #1;
        chk_out("reset", 0, 1'b0, 9'h000);
        req_i = 9'h1FF;
        rst = 1'b0;
        model_reset();
        step();
        chk_out("post_reset", 0, 1'b0, 9'h000);

        for (int r = 0; r < 17; r++) begin
            req_i = tbl[r].req;
            ready_i = tbl[r].rdy;
            step();
            chk_out($sformatf("vec%0d", r), tbl[r].code, tbl[r].v, tbl[r].pend);
        end

        req_i = '0;
        ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_out($sformatf("fair%0d", k), m_code, m_valid, m_pend);
`ifndef PENC_RR_EN
            chk("fair_fixed", 32'(code_o), 32'd9);
`endif
        end

        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 1'b0, 9'h000);
        model_reset();
        @(posedge clk);
        #1;
        chk_out("rst_held", 0, 1'b0, 9'h000);
        req_i = '1;
        rst = 1'b0;
        step();
        chk_out("rst_release", 0, 1'b0, 9'h000);

        for (int c = 0; c < 400; c++) begin
            req_i = ~(N'($urandom) & N'($urandom) & N'($urandom));
            ready_i = ($urandom_range(0, 3) != 0);
            step();
            chk_out("rand", m_code, m_valid, m_pend);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
